// File: rtl/note_pkg.sv
// ---------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note path (voice allocator and the note-stream
// generator behind it).
//   NOTE_W / OCT_W / CODE_W : widths of the note index, octave and the
//                             combined {octave,note} code.
//   note_code_t             : one voice code.
//   alloc_state_t           : voice allocator FSM states.
// ---------------------------------------------------------------------------
package note_pkg;

  localparam int NOTE_W = 6;
  localparam int OCT_W  = 3;
  localparam int CODE_W = OCT_W + NOTE_W;

  typedef logic [CODE_W-1:0] note_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
  } alloc_state_t;

endpackage

// File: rtl/voice_slot.sv
// ---------------------------------------------------------------------------
// voice_slot
// One voice slot of the allocator: holds the {octave,note} code, the gate bit
// and a saturating age counter (and, under SUSTAIN_EN, a sustain hold bit).
// All changes are driven by one-cycle strobes from the allocator.
//   clk, reset        : clock, asynchronous active-high reset
//   load_i, code_i    : capture code_i, open the gate, age := 0
//   clear_gate_i      : close the gate (code kept)
//   reset_age_i       : retrigger: age := 0, slot stays sounding
//   inc_age_i         : age := age + 1, saturating at all-ones
//   set_hold_i        : (SUSTAIN_EN) release seen while sustain pedal down
//   release_hold_i    : (SUSTAIN_EN) pedal lifted: held slots close the gate
//   code_o/gate_o/age_o : slot state
// Optional feature macro: SUSTAIN_EN.
// ---------------------------------------------------------------------------
module voice_slot #(
  parameter int CODE_W = 9,
  parameter int AGE_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              clear_gate_i,
  input  logic              reset_age_i,
  input  logic              inc_age_i,
`ifdef SUSTAIN_EN
  input  logic              set_hold_i,
  input  logic              release_hold_i,
`endif
  output logic [CODE_W-1:0] code_o,
  output logic              gate_o,
  output logic [AGE_W-1:0]  age_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [CODE_W-1:0] code_q, code_d;
  logic              gate_q, gate_d;
  logic [AGE_W-1:0]  age_q,  age_d;
`ifdef SUSTAIN_EN
  logic              hold_q, hold_d;
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first,
    // so no path through this block leaves a signal unassigned (no latches).
    code_d = code_q;
    gate_d = gate_q;
    age_d  = age_q;
`ifdef SUSTAIN_EN
    hold_d = hold_q;
`endif
    if (load_i) begin
      code_d = code_i;
      gate_d = 1'b1;
      age_d  = '0;
`ifdef SUSTAIN_EN
      hold_d = 1'b0;
`endif
    end else begin
      if (clear_gate_i) gate_d = 1'b0;
`ifdef SUSTAIN_EN
      if (set_hold_i) hold_d = 1'b1;
      if (release_hold_i && hold_q) begin
        gate_d = 1'b0;
        hold_d = 1'b0;
      end
`endif
      if (reset_age_i) begin
        // A retrigger wins over a pedal release landing on the same edge:
        // the key is down again, so the slot keeps sounding.
        age_d  = '0;
        gate_d = 1'b1;
`ifdef SUSTAIN_EN
        hold_d = 1'b0;
`endif
      end else if (inc_age_i && (age_q != AGE_MAX)) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      code_q <= '0;
      gate_q <= 1'b0;
      age_q  <= '0;
`ifdef SUSTAIN_EN
      hold_q <= 1'b0;
`endif
    end else begin
      code_q <= code_d;
      gate_q <= gate_d;
      age_q  <= age_d;
`ifdef SUSTAIN_EN
      hold_q <= hold_d;
`endif
    end
  end

  assign code_o = code_q;
  assign gate_o = gate_q;
  assign age_o  = age_q;

endmodule

// File: rtl/note_voice_allocator.sv
// ---------------------------------------------------------------------------
// note_voice_allocator
// Polyphonic voice allocator. Key press/release events arrive through a
// valid/ready handshake; each event scans the slots one per cycle (SCAN) and
// is committed in APPLY. A press retriggers a slot already holding the same
// code, else takes the lowest free slot, else steals the oldest gated slot.
// A release closes the gate of the slot holding the same full code.
//   clk, reset          : clock, asynchronous active-high reset
//   octave              : current octave, sampled at event acceptance
//   ev_valid / ev_ready : event handshake
//   ev_on, ev_note      : 1 = press / 0 = release, note index
//   sustain             : (SUSTAIN_EN only) sustain pedal level
//   voice_code          : packed codes, slot v at [v*CODE_W +: CODE_W]
//   voice_gate          : per-slot gate
//   steal_pulse         : one-cycle pulse after a held slot was stolen
// Latency: accept at E0, outputs change at E(NUM_VOICES+1).
// Optional feature macro: SUSTAIN_EN.
// ---------------------------------------------------------------------------
module note_voice_allocator #(
  parameter int  NUM_VOICES = 2,
  parameter int  NOTE_W     = note_pkg::NOTE_W,
  parameter int  OCT_W      = note_pkg::OCT_W,
  parameter int  AGE_W      = 4,
  localparam int CODE_W     = OCT_W + NOTE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OCT_W-1:0]             octave,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
`ifdef SUSTAIN_EN
  input  logic                         sustain,
`endif
  output logic [NUM_VOICES*CODE_W-1:0] voice_code,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         steal_pulse
);

  import note_pkg::alloc_state_t;
  import note_pkg::IDLE;
  import note_pkg::SCAN;
  import note_pkg::APPLY;

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CODE_W-1:0] ev_code_q, ev_code_d;
  logic              ev_on_q, ev_on_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              old_found_q, old_found_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;
  logic              steal_q, steal_d;
  logic [IDX_W-1:0]  apply_tgt;

  logic [CODE_W-1:0] slot_code [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;

  logic [NUM_VOICES-1:0] load_s, clear_s, rst_age_s, inc_s;
`ifdef SUSTAIN_EN
  logic [NUM_VOICES-1:0] set_hold_s;
  logic                  sustain_q;
  logic                  release_hold;

  // Pedal lift is acted on at the first edge that sees it low.
  assign release_hold = sustain_q & ~sustain;
`endif

  // Slot currently under examination during SCAN.
  logic [CODE_W-1:0] cur_code;
  logic              cur_gate;
  logic [AGE_W-1:0]  cur_age;

  assign cur_code = slot_code[idx_q];
  assign cur_gate = slot_gate[idx_q];
  assign cur_age  = slot_age[idx_q];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_code_d     = ev_code_q;
    ev_on_d       = ev_on_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    steal_d       = 1'b0;
    ev_ready      = 1'b0;
    apply_tgt     = '0;
    load_s        = '0;
    clear_s       = '0;
    rst_age_s     = '0;
    inc_s         = '0;
`ifdef SUSTAIN_EN
    set_hold_s    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          ev_code_d     = {octave, ev_note};
          ev_on_d       = ev_on;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        if (cur_gate && (cur_code == ev_code_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!cur_gate && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strictly greater keeps the lowest index on an age tie.
        if (cur_gate && (!old_found_q || (cur_age > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = cur_age;
        end
        if (idx_q == LAST_IDX) state_d = APPLY;
        else                   idx_d   = idx_q + 1'b1;
      end

      APPLY: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (match_found_q) begin
            apply_tgt              = match_idx_q;
            rst_age_s[match_idx_q] = 1'b1;
          end else if (free_found_q) begin
            apply_tgt           = free_idx_q;
            load_s[free_idx_q]  = 1'b1;
          end else begin
            apply_tgt           = old_idx_q;
            load_s[old_idx_q]   = 1'b1;
            steal_d             = 1'b1;
          end
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (slot_gate[v] && (IDX_W'(v) != apply_tgt)) inc_s[v] = 1'b1;
          end
        end else if (match_found_q) begin
`ifdef SUSTAIN_EN
          if (sustain) set_hold_s[match_idx_q] = 1'b1;
          else         clear_s[match_idx_q]    = 1'b1;
`else
          clear_s[match_idx_q] = 1'b1;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ev_code_q     <= '0;
      ev_on_q       <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= 1'b0;
`ifdef SUSTAIN_EN
      sustain_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_code_q     <= ev_code_d;
      ev_on_q       <= ev_on_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
`ifdef SUSTAIN_EN
      sustain_q     <= sustain;
`endif
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(
      .CODE_W(CODE_W),
      .AGE_W (AGE_W)
    ) u_slot (
      .clk           (clk),
      .reset         (reset),
      .load_i        (load_s[v]),
      .code_i        (ev_code_q),
      .clear_gate_i  (clear_s[v]),
      .reset_age_i   (rst_age_s[v]),
      .inc_age_i     (inc_s[v]),
`ifdef SUSTAIN_EN
      .set_hold_i    (set_hold_s[v]),
      .release_hold_i(release_hold),
`endif
      .code_o        (slot_code[v]),
      .gate_o        (slot_gate[v]),
      .age_o         (slot_age[v])
    );
    assign voice_code[v*CODE_W +: CODE_W] = slot_code[v];
  end

  assign voice_gate  = slot_gate;
  assign steal_pulse = steal_q;

endmodule

// File: doc/note_voice_allocator.md
Name: note_voice_allocator

Overview:
- Polyphonic voice allocator sitting in front of the note-stream generator.
- Accepts key press/release events through a valid/ready handshake.
- Assigns each press to one of NUM_VOICES voice slots: retrigger if the note is already held, else the lowest free slot, else steals the oldest slot.
- Drives a per-voice 9-bit note code {octave,note} and a gate bit.

Parameters:
- NUM_VOICES, 2, number of voice slots; range 2..8.
- NOTE_W, 6, note index width.
- OCT_W, 3, octave width; code width is CODE_W = OCT_W+NOTE_W = 9.
- AGE_W, 4, width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- octave  in  OCT_W  current octave; sampled only at event acceptance.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = key press, 0 = key release.
- ev_note  in  NOTE_W  note index of the event.
- voice_code  out  NUM_VOICES*CODE_W  packed; slot v occupies bits [v*9+8 : v*9].
- voice_gate  out  NUM_VOICES  slot sounding.
- steal_pulse  out  1  one-cycle pulse when a held slot is stolen.

Behaviour:
- Reset (async, any state, including mid-SCAN): voice_code=0, voice_gate=0, ages=0, steal_pulse=0, FSM=IDLE, ev_ready=1 once reset deasserts. An in-flight event is discarded.
- FSM states: IDLE, SCAN, APPLY.
- IDLE:
  - ev_ready=1.
  - On ev_valid&&ev_ready: latch {ev_on, octave, ev_note} into the event code, clear idx and match/free flags, go to SCAN.
- SCAN:
  - ev_ready=0.
  - Examine one slot per cycle (slot idx), recording:
    - the first slot whose gate=1 and code equals the event code (match);
    - the first slot with gate=0 (free);
    - the gated slot with the highest age (oldest). Ties go to the lowest index.
  - After idx=NUM_VOICES-1, go to APPLY.
- APPLY: commit the result on this edge, then go to IDLE.
  - Press with match: age[match]=0; code and gate unchanged.
  - Press, no match, free slot: code[free]=event code, gate[free]=1, age[free]=0.
  - Press, no match, no free slot: overwrite the oldest slot, age=0, gate stays 1, steal_pulse=1 for exactly this cycle.
  - Every press also increments the age of all other gated slots, saturating at 2^AGE_W-1.
  - Release with match: gate[match]=0; code is retained.
  - Release with no match: ignored, no output change.
- Timing:
  - Accept at edge E0; outputs update at edge E(NUM_VOICES+1).
  - ev_ready returns high the cycle after APPLY.
  - Throughput is one event per NUM_VOICES+2 cycles.
- Octave changes while an event is in flight do not affect it.
- A release matches on the full 9-bit code, so it must arrive at the same octave as its press.

Optional Feature:
- Macro: SUSTAIN_EN.
- With the macro defined:
  - Extra input port sustain (1 bit) and an internal per-voice hold bit.
  - A release that matches while sustain=1 sets hold[v] and leaves the gate at 1.
  - On the first cycle sustain is seen low (falling edge, registered), every slot with hold=1 gets gate=0 and hold=0.
  - A press that matches a held slot clears hold.
  - Held slots count as gated for stealing.
- Without the macro: no sustain port and no hold bits; releases clear the gate immediately.

Decomposition:
- Package note_pkg holds:
  - localparams NOTE_W, OCT_W, CODE_W;
  - typedef note_code_t (logic [CODE_W-1:0]);
  - enum alloc_state_t {IDLE, SCAN, APPLY}.
  It is shared with the stream generator.
- Sub-module voice_slot, instantiated NUM_VOICES times. Each holds code, gate, the saturating age and, under SUSTAIN_EN, hold. It has load, clear-gate, reset-age and age-increment strobes.
- The scan and FSM live in the top module.

Test Plan:
- Reset asserted mid-SCAN -> all outputs 0 immediately (asynchronous); ev_ready=1 after release; the next event is processed normally.
- octave=4, press note 9 -> voice_code slot0=9'h109, gate=2'b01 exactly 3 edges after acceptance; ev_ready low for 3 cycles.
- Press 9 then 12 at octave 4 -> slot1=9'h10C, gate=2'b11; a repeated press of 9 leaves codes unchanged and resets slot0 age to 0.
- Slots full {9'h109 (age 1), 9'h10C (age 0)}, press note 2 -> slot0=9'h102, steal_pulse high exactly 1 cycle, gate=2'b11.
- Release 12 at octave 4 -> gate=2'b01 and slot1 code retained; release 12 at octave 5 -> no change.
- SUSTAIN_EN: sustain=1, release 9 -> gate stays 1; sustain falls -> gate[0]=0 within 1 cycle.
